match_lane_arbiter: RTL

- Shares one pipelined phase-match tree among BEAT_SIZE per-lane phase FIFOs; each FIFO entry is {last, pos, phase}.
- Round-robin grant across ready lanes. Returned disparities are routed to that lane's disparity FIFO.
- Enforces a row barrier: no lane starts row N+1 until every lane has issued its row-N last entry and all results have drained.
- Sits between the stream control front end's phase/disparity buffers and the match tree.

---
 rtl/match_lane_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/match_lane_arbiter.sv
// Round-robin arbiter sharing one match tree across per-lane phase FIFOs, with a row barrier.
// Request stage is registered (1 cycle FIFO-to-valid); responses are steered to dis FIFOs combinationally.
module match_lane_arbiter #(
  parameter int BEAT_SIZE  = 8,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_OUT    = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [BEAT_SIZE-1:0]                      phase_buf_empty,
  input  logic [BEAT_SIZE-1:0][2*DATA_WIDTH:0]      phase_buf_dout,
  output logic [BEAT_SIZE-1:0]                      phase_buf_rd_en,
  output logic                                      mt_req_valid,
  input  logic                                      mt_req_ready,
  output logic [DATA_WIDTH-1:0]                     mt_req_phase,
  output logic [DATA_WIDTH-1:0]                     mt_req_pos,
  output logic [$clog2(BEAT_SIZE)-1:0]              mt_req_lane,
  output logic                                      mt_req_last,
  input  logic                                      mt_rsp_valid,
  input  logic [$clog2(BEAT_SIZE)-1:0]              mt_rsp_lane,
  input  logic [DATA_WIDTH-1:0]                     mt_rsp_disp,
  input  logic                                      mt_rsp_last,
  output logic [BEAT_SIZE-1:0]                      dis_buf_wr_en,
  output logic [BEAT_SIZE-1:0][DATA_WIDTH:0]        dis_buf_din,
  input  logic [BEAT_SIZE-1:0]                      dis_buf_pfull,
  output logic                                      row_done,
  output logic                                      busy
);

  localparam int LW = $clog2(BEAT_SIZE);
  localparam int CW = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                         state, state_nxt;
  logic [LW-1:0]                  ptr;
  logic [BEAT_SIZE-1:0][CW-1:0]   outstanding;
  logic [BEAT_SIZE-1:0]           lane_done, lane_done_nxt;
  logic [BEAT_SIZE-1:0]           eligible;
  logic                           any_elig;
  logic                           load;
  logic [LW-1:0]                  winner;
  logic [LW-1:0]                  idx;
  logic [2*DATA_WIDTH:0]          win_ent;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < BEAT_SIZE; i++) begin
      eligible[i] = !phase_buf_empty[i] && !lane_done[i] &&
                     (outstanding[i] < CW'(MAX_OUT)) && !dis_buf_pfull[i] &&
                     (state == S_RUN);
    end
  end

  // Scan from farthest to nearest offset so the nearest lane after ptr wins.
  always_comb begin
    winner   = '0;
    any_elig = 1'b0;
    idx      = '0;
    for (int off = BEAT_SIZE; off >= 1; off--) begin
      idx = LW'((int'(ptr) + off) % BEAT_SIZE);
      if (eligible[idx]) begin
        winner   = idx;
        any_elig = 1'b1;
      end
    end
  end

  assign load    = rst_n && (!mt_req_valid || mt_req_ready) && any_elig;
  assign win_ent = phase_buf_dout[winner];

  always_comb begin
    phase_buf_rd_en = '0;
    if (load) phase_buf_rd_en[winner] = 1'b1;
  end

  always_comb begin
    dis_buf_wr_en = '0;
    if (rst_n && mt_rsp_valid) dis_buf_wr_en[mt_rsp_lane] = 1'b1;
    for (int i = 0; i < BEAT_SIZE; i++) dis_buf_din[i] = {mt_rsp_last, mt_rsp_disp};
  end

  always_comb begin
    lane_done_nxt = lane_done;
    if (state == S_DONE)
      lane_done_nxt = '0;
    else if (load && win_ent[2*DATA_WIDTH])
      lane_done_nxt[winner] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   if (&lane_done_nxt) state_nxt = S_DRAIN;
      S_DRAIN: if (!(|outstanding) && !mt_req_valid) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_RUN;
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_RUN;
      lane_done <= '0;
      ptr       <= '0;
    end else begin
      state     <= state_nxt;
      lane_done <= lane_done_nxt;
      if (load) ptr <= winner;
    end
  end

  // Simultaneous issue and response on a lane cancel; a stray response never underflows.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      for (int i = 0; i < BEAT_SIZE; i++) begin
        if (phase_buf_rd_en[i] && !dis_buf_wr_en[i])
          outstanding[i] <= outstanding[i] + CW'(1);
        else if (!phase_buf_rd_en[i] && dis_buf_wr_en[i] && (outstanding[i] != '0))
          outstanding[i] <= outstanding[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mt_req_valid <= 1'b0;
      mt_req_phase <= '0;
      mt_req_pos   <= '0;
      mt_req_lane  <= '0;
      mt_req_last  <= 1'b0;
    end else if (load) begin
      mt_req_valid <= 1'b1;
      mt_req_phase <= win_ent[DATA_WIDTH-1:0];
      mt_req_pos   <= win_ent[2*DATA_WIDTH-1:DATA_WIDTH];
      mt_req_lane  <= winner;
      mt_req_last  <= win_ent[2*DATA_WIDTH];
    end else if (mt_req_ready) begin
      mt_req_valid <= 1'b0;
    end
  end

  assign row_done = (state == S_DONE);
  assign busy     = (state != S_RUN) || (|outstanding) || mt_req_valid;

  a_rsp_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    mt_rsp_valid |-> (outstanding[mt_rsp_lane] != '0));

endmodule
